// File: rtl/sobel_pkg.sv
// sobel_pkg: shared widths, pixel/gradient types and a widening helper for the Sobel pipeline
package sobel_pkg;
    localparam int PIXEL_W    = 8;
    localparam int GRAD_W     = 10;
    localparam int GRAD_SHIFT = 3;
    typedef logic [PIXEL_W-1:0]        pixel_t;
    typedef logic signed [GRAD_W-1:0]  grad_t;
    typedef logic signed [11:0]        acc_t;
    function automatic acc_t widen(input pixel_t p);
        return acc_t'({4'b0000, p});
    endfunction
endpackage

// File: rtl/sobel_line_buffer.sv
// sobel_line_buffer: two row-deep pixel history, read and shifted at the same column each accepted pixel
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [$clog2(IMG_WIDTH)-1:0] addr,
    input  pixel_t                       din,
    output pixel_t                       prev1,
    output pixel_t                       prev2
);
    pixel_t lb0 [IMG_WIDTH];
    pixel_t lb1 [IMG_WIDTH];
    assign prev1 = lb0[addr];
    assign prev2 = lb1[addr];
    // push the column down one row; reads above see the pre-write contents
    always_ff @(posedge clk) begin
        if (we) begin
            lb1[addr] <= lb0[addr];
            lb0[addr] <= din;
        end
    end
endmodule

// File: rtl/sobel_gradient.sv
// sobel_gradient: streaming 3x3 Sobel gx/gy generator over raster-order pixels
module sobel_gradient
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   frame_start,
    input  pixel_t pixel_in,
    input  logic   pixel_valid,
    output grad_t  gx,
    output grad_t  gy,
    output logic   calc_done,
    output logic   frame_done
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    logic [CW-1:0] col, cur_col, nxt_col;
    logic [RW-1:0] row, cur_row, nxt_row;
    pixel_t        w [3][3];
    pixel_t        prev1, prev2;
    logic          win_valid, win_last;
    acc_t          gx_raw, gy_raw;

    sobel_line_buffer #(.IMG_WIDTH(IMG_WIDTH)) u_lb (
        .clk   (clk),
        .we    (pixel_valid),
        .addr  (cur_col),
        .din   (pixel_in),
        .prev1 (prev1),
        .prev2 (prev2)
    );

    // frame_start forces the current pixel to (0,0); compute the following position
    always_comb begin
        cur_col = frame_start ? '0 : col;
        cur_row = frame_start ? '0 : row;
        nxt_col = (cur_col == COL_LAST) ? '0 : cur_col + 1'b1;
        nxt_row = (cur_col != COL_LAST) ? cur_row : (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
    end

    // raster position advances only on accepted pixels
    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (pixel_valid) begin
            col <= nxt_col;
            row <= nxt_row;
        end else if (frame_start) begin
            col <= '0;
            row <= '0;
        end
    end

    // shift the 3x3 window left and flag whether it is a full interior neighbourhood
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 3; r++)
                for (int k = 0; k < 3; k++)
                    w[r][k] <= '0;
            win_valid <= 1'b0;
            win_last  <= 1'b0;
        end else begin
            win_valid <= pixel_valid && cur_row >= RW'(2) && cur_col >= CW'(2);
            win_last  <= cur_row == ROW_LAST && cur_col == COL_LAST;
            if (pixel_valid) begin
                for (int r = 0; r < 3; r++) begin
                    w[r][0] <= w[r][1];
                    w[r][1] <= w[r][2];
                end
                w[0][2] <= prev2;
                w[1][2] <= prev1;
                w[2][2] <= pixel_in;
            end
        end
    end

    assign gx_raw = (widen(w[0][2]) + widen(w[1][2]) + widen(w[1][2]) + widen(w[2][2]))
                  - (widen(w[0][0]) + widen(w[1][0]) + widen(w[1][0]) + widen(w[2][0]));
    assign gy_raw = (widen(w[2][0]) + widen(w[2][1]) + widen(w[2][1]) + widen(w[2][2]))
                  - (widen(w[0][0]) + widen(w[0][1]) + widen(w[0][1]) + widen(w[0][2]));

    // register scaled gradients; they hold between results
    always_ff @(posedge clk) begin
        if (rst) begin
            gx         <= '0;
            gy         <= '0;
            calc_done  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            calc_done  <= win_valid;
            frame_done <= win_valid && win_last;
            if (win_valid) begin
                gx <= grad_t'(gx_raw >>> GRAD_SHIFT);
                gy <= grad_t'(gy_raw >>> GRAD_SHIFT);
            end
        end
    end
endmodule

// File: doc/sobel_gradient.md
# sobel_gradient

Streaming Sobel gradient generator that feeds the magnitude stage of the edge-detection pipeline. Accepts raster-order 8-bit grayscale pixels and maintains two line buffers plus a 3x3 window. For every interior pixel it produces scaled signed gradients `gx` and `gy`, with a one-cycle `calc_done` strobe. It is the producer end of the `gx`/`gy`/`calc_done` interface consumed by `magnitude`.

## Interface
- `IMG_WIDTH`, default 64: pixels per row, must be ≥3.
- `IMG_HEIGHT`, default 64: rows per frame, must be ≥3.
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `frame_start`  in  1  one-cycle pulse that restarts the row/column counters at (0,0).
- `pixel_in`  in  8  unsigned grayscale pixel.
- `pixel_valid`  in  1  qualifies `pixel_in` and is sampled every rising edge.
- `gx`  out  10  signed horizontal gradient, two's complement.
- `gy`  out  10  signed vertical gradient, two's complement.
- `calc_done`  out  1  one-cycle strobe meaning `gx`/`gy` hold a new result.
- `frame_done`  out  1  one-cycle strobe coincident with the last `calc_done` of a frame.

## Operation
- Counters: `col` runs 0..IMG_WIDTH-1 and `row` runs 0..IMG_HEIGHT-1.
  - They advance only on an accepted pixel (`pixel_valid`=1).
  - `col` wraps to 0 and increments `row`.
  - After (IMG_HEIGHT-1, IMG_WIDTH-1), both counters return to (0,0), so back-to-back frames need no `frame_start`.
- Line buffers: `lb0[c]` holds the previous row and `lb1[c]` holds the row two back. An accepted pixel at column c does three things:
  - New window column, top to bottom, is {`lb1[c]`, `lb0[c]`, `pixel_in`}.
  - `lb1[c]` ← `lb0[c]`.
  - `lb0[c]` ← `pixel_in`.
- Window: 3x3 register array `w[r][k]`, r=0 top, k=2 newest column. Each accepted pixel shifts it one column left.
- Window-valid flag: registered with the shift, set iff the accepted pixel had `row`≥2 and `col`≥2, using counter values before increment. Border pixels produce no output, giving (IMG_WIDTH-2)*(IMG_HEIGHT-2) results per frame.
- Arithmetic, in 12-bit signed:
  - gx_raw = (w02 + 2·w12 + w22) − (w00 + 2·w10 + w20)
  - gy_raw = (w20 + 2·w21 + w22) − (w00 + 2·w01 + w02)
  - Range ±1020.
- Output scaling: `gx` = gx_raw >>> 3 and `gy` = gy_raw >>> 3, an arithmetic (floor) shift with range −128..127. Sign-extend to 10 bits. No saturation is needed.
- `gx`/`gy` are registered and hold their value until the next `calc_done`.
- `frame_done`=1 with the `calc_done` whose window came from pixel (IMG_HEIGHT-1, IMG_WIDTH-1).

## Timing
- Reset, while `rst`=1 at a rising edge:
  - `gx`=0, `gy`=0, `calc_done`=0, `frame_done`=0.
  - Counters and window cleared, window-valid cleared.
  - Line-buffer contents are not reset and are don't-care.
- Latency: pixel sampled at edge k updates the window at k. `gx`, `gy` and `calc_done` update at edge k+1.
  - `calc_done` is high for exactly one cycle after k+1.
  - Throughput is one result per clock.
- `pixel_valid` gaps: window and counters hold. `calc_done` stays 0 unless a result is already in flight.
- `frame_start` at edge k:
  - Counters go to (0,0) before the pixel is indexed; a simultaneous valid pixel is taken as (0,0).
  - A result already in flight from edge k−1 still emits `calc_done` at k+1.
  - No output occurs until the new frame reaches (2,2).
- `frame_start` together with `rst`: `rst` wins.
- Reset mid-frame: the in-flight result is discarded and `calc_done` stays 0.

## Structure
- Shared package `sobel_pkg`:
  - Constants `PIXEL_W`=8, `GRAD_W`=10, `GRAD_SHIFT`=3.
  - Typedefs `pixel_t` (logic [7:0]) and `grad_t` (logic signed [9:0]). `magnitude` reuses `grad_t`.
- One sub-module, `sobel_line_buffer`: two IMG_WIDTH×8 arrays, read at column c and written at column c in the same cycle (read-before-write), with no reset.

## Test plan
- Reset, then idle -> `gx`=0, `gy`=0, `calc_done`=0 and `frame_done`=0 for 10 cycles.
- 4x4 flat frame, all pixels 100, continuous valid -> exactly 4 `calc_done` pulses, each 1 cycle after pixels (2,2), (2,3), (3,2), (3,3) are sampled. All have `gx`=`gy`=0, and `frame_done` is set with the 4th.
- 4x4 vertical edge, columns 0–1 = 0 and columns 2–3 = 255 -> first result `gx`=127, `gy`=0; second result `gx`=127, `gy`=0.
- 4x4 horizontal edge, rows 0–1 = 255 and rows 2–3 = 0 -> `gy`=−128 (10'b1110000000) and `gx`=0 for all 4 results.
- Repeat the vertical-edge frame with `pixel_valid` low every other cycle -> identical `gx`/`gy` sequence, each `calc_done` exactly 1 cycle after its qualifying pixel and never during a gap.
- Send 6 pixels, then `frame_start` with a valid pixel, then a full 4x4 frame -> no `calc_done` before new pixel (2,2). Exactly 4 results follow, matching the flat-frame case.
